// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: captures two WIDTH-bit operands on start and adds them LSB-first,
// one bit per clock, through a single full-adder cell with a registered carry.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  // Holds the WIDTH-1 bits produced so far; the final bit joins it on the way to sum.
  logic [WIDTH-2:0] res_q;
  logic             c_q;
  logic [CntW-1:0]  cnt_q;

  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;
  logic [WIDTH-2:0] s_top;

  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    ha1_c = a_q[0] & b_q[0];
    ha2_s = ha1_s ^ c_q;
    ha2_c = ha1_s & c_q;
    fa_c  = ha1_c | ha2_c;
    s_top = '0;
    s_top[WIDTH-2] = ha2_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= 1'b0;
            cnt_q   <= CntLoad;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= fa_c;
          res_q <= (res_q >> 1) | s_top;
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= {ha2_s, res_q};
            carry   <= fa_c;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of serial_adder at WIDTH=8 plus an exhaustive sweep of a WIDTH=4 instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, carry;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, carry4;
  logic [3:0] sum4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .carry (carry4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 8-bit instance, checking busy window, latency and result.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                     input logic [7:0] es, input logic ec);
    int lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    tick();
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      busy_ok &= busy;
      tick();
      lat++;
    end
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    tick();
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int lat;
    int extra;
    logic hold_ok;

    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    op8("v35_1a", 8'h35, 8'h1A, 8'h4F, 1'b0);
    op8("vff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    op8("vff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    op8("v00_00", 8'h00, 8'h00, 8'h00, 1'b0);

    // Start during RUN with changing operands must be ignored.
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h20;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (2) begin tick(); lat++; end
    start = 1'b1; a = 8'hAA; b = 8'h55;
    tick(); lat++;
    start = 1'b0; a = 8'hFF; b = 8'hFF;
    while (!done && lat < 20) begin tick(); lat++; end
    check("mid_lat", 32'(lat), 32'd8);
    check("mid_sum", 32'(sum), 32'h30);
    check("mid_carry", 32'(carry), 32'd0);
    extra = 0;
    repeat (12) begin tick(); if (done) extra++; end
    check("mid_extra_done", 32'(extra), 32'd0);
    check("mid_idle_busy", 32'(busy), 32'd0);

    // Reset on the 4th RUN cycle aborts; sum was 0x30 beforehand.
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    extra = 0;
    repeat (12) begin tick(); if (done || busy) extra++; end
    check("abort_quiet", 32'(extra), 32'd0);
    op8("v80_80", 8'h80, 8'h80, 8'h00, 1'b1);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02;
    tick();
    a = 8'h03; b = 8'h04;
    lat = 0;
    while (!done && lat < 20) begin tick(); lat++; end
    check("b2b_lat1", 32'(lat), 32'd8);
    check("b2b_sum1", 32'(sum), 32'h03);
    check("b2b_carry1", 32'(carry), 32'd0);
    tick();
    start = 1'b0;
    check("b2b_busy2", 32'(busy), 32'd1);
    lat = 1;
    hold_ok = 1'b1;
    while (!done && lat < 20) begin
      hold_ok &= (sum == 8'h03);
      tick();
      lat++;
    end
    check("b2b_hold", 32'(hold_ok), 32'd1);
    check("b2b_gap", 32'(lat), 32'd9);
    check("b2b_sum2", 32'(sum), 32'h07);
    check("b2b_carry2", 32'(carry), 32'd0);
    repeat (2) tick();

    // Exhaustive WIDTH=4 sweep.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [4:0] exp5;
        exp5 = 5'(i) + 5'(j);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'(i); b4 = 4'(j);
        tick();
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin tick(); lat++; end
        check($sformatf("w4_%0d_%0d_lat", i, j), 32'(lat), 32'd4);
        check($sformatf("w4_%0d_%0d_sum", i, j), 32'(sum4), 32'(exp5[3:0]));
        check($sformatf("w4_%0d_%0d_carry", i, j), 32'(carry4), 32'(exp5[4]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
